// File: rtl/psg_arb_pkg.sv
// Shared types and sizing for the PSG bus arbitration tree.
// Channel count, index width and the arbiter state encoding.
package psg_arb_pkg;

  localparam int NREQ = 8;
  localparam int IW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

endpackage

// File: rtl/psg_rr_pick.sv
// Combinational round-robin search: first set req at or after ptr.
// Rotates req so ptr lands on bit 0, then takes the lowest set bit.
module psg_rr_pick
  import psg_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IW'(i);
      end
    end
  end

  // Index arithmetic wraps naturally at NREQ = 2**IW.
  assign idx = ptr + off;

endmodule

// File: rtl/psg_rr_bus_arb.sv
// Round-robin upstream bus arbiter for the PSG wave table channels.
// Holds a grant until ack or timeout, then idles one ce edge in REL.
module psg_rr_bus_arb #(
  parameter int NREQ    = psg_arb_pkg::NREQ,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [NREQ-1:0]         req,
  input  logic                    ack,
  output logic                    cyc,
  output logic [NREQ-1:0]         sel,
  output logic [psg_arb_pkg::IW-1:0] seln,
  output logic [NREQ-1:0]         done,
  output logic                    tmo
);

  import psg_arb_pkg::*;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     seln_q, seln_d;
  logic [7:0]        timer_q, timer_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     ptr_nxt;

  psg_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ptr_nxt = seln_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      seln_q  <= '0;
      timer_q <= '0;
      sel_q   <= '0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      seln_q  <= seln_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // done/tmo default low every clk so pulses last one clk even with ce=0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    seln_d  = seln_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    done_d  = '0;
    tmo_d   = 1'b0;
    if (ce) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_d = ST_BUS;
            sel_d   = NREQ'(1) << pick_idx;
            seln_d  = pick_idx;
            timer_d = '0;
          end
        end
        ST_BUS: begin
          if (ack) begin
            done_d  = NREQ'(1) << seln_q;
            ptr_d   = ptr_nxt;
            sel_d   = '0;
            state_d = ST_REL;
          end else if (timer_q == TLIM) begin
            tmo_d   = 1'b1;
            ptr_d   = ptr_nxt;
            sel_d   = '0;
            state_d = ST_REL;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        ST_REL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cyc  = (state_q == ST_BUS);
  assign sel  = sel_q;
  assign seln = seln_q;
  assign done = done_q;
  assign tmo  = tmo_q;

  a_sel_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(sel));
  a_cyc_sel: assert property (
    @(posedge clk) disable iff (!rst_n) cyc == (sel != '0));
  a_done_tmo: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(done) && !(tmo && (done != '0)));

endmodule
